// File: rtl/draw_bounding_box.sv
// Raster-scans a latched bounding box into the 6x6 frame RAM write port, one pixel per cycle.
// Draws either the outline only or a solid fill; rejected boxes finish with done and err.
module draw_bounding_box #(
  parameter int X_RES   = 6,
  parameter int Y_RES   = 6,
  parameter int XSZ     = 3,
  parameter int YSZ     = 3,
  parameter int ADDR_SZ = 6,
  parameter int COL_SZ  = 3
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               fill,
  input  logic [YSZ-1:0]     mostTop,
  input  logic [YSZ-1:0]     mostBottom,
  input  logic [XSZ-1:0]     mostLeft,
  input  logic [XSZ-1:0]     mostRight,
  input  logic [COL_SZ-1:0]  colour,
  output logic [ADDR_SZ-1:0] mem_address,
  output logic [COL_SZ-1:0]  mem_data,
  output logic               wren,
  output logic               busy,
  output logic               done,
  output logic               err
);

  // state | meaning
  // IDLE  | waiting for start; box and colour latched on start
  // SCAN  | one pixel per cycle from (left,top) to (right,bottom)
  // DONE  | one-cycle done pulse after a complete draw
  // ERR   | one-cycle done+err pulse for a rejected box, no writes
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2,
    ERR  = 2'd3
  } stateT;

  localparam logic [XSZ-1:0] X_MAX = XSZ'(X_RES - 1);
  localparam logic [YSZ-1:0] Y_MAX = YSZ'(Y_RES - 1);

  stateT state, nextState;

  logic [YSZ-1:0]    topQ, bottomQ, yQ;
  logic [XSZ-1:0]    leftQ, rightQ, xQ;
  logic [COL_SZ-1:0] colourQ;
  logic              fillQ;

  logic boxValid;
  logic lastCol;
  logic lastRow;
  logic onEdge;

  assign boxValid = (mostLeft <= mostRight) && (mostTop <= mostBottom) &&
                    (mostRight <= X_MAX) && (mostBottom <= Y_MAX);
  assign lastCol  = (xQ == rightQ);
  assign lastRow  = (yQ == bottomQ);
  assign onEdge   = (xQ == leftQ) || lastCol || (yQ == topQ) || lastRow;

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      topQ    <= '0;
      bottomQ <= '0;
      leftQ   <= '0;
      rightQ  <= '0;
      colourQ <= '0;
      fillQ   <= 1'b0;
      xQ      <= '0;
      yQ      <= '0;
    end else begin
      state <= nextState;
      case (state)
        IDLE: begin
          if (start) begin
            topQ    <= mostTop;
            bottomQ <= mostBottom;
            leftQ   <= mostLeft;
            rightQ  <= mostRight;
            colourQ <= colour;
            fillQ   <= fill;
            xQ      <= mostLeft;
            yQ      <= mostTop;
          end
        end
        SCAN: begin
          // y holds at bottom on the final pixel so it never leaves the box
          if (lastCol) begin
            xQ <= leftQ;
            if (!lastRow) yQ <= yQ + 1'b1;
          end else begin
            xQ <= xQ + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    nextState   = state;
    mem_address = '0;
    mem_data    = '0;
    wren        = 1'b0;
    busy        = 1'b0;
    done        = 1'b0;
    err         = 1'b0;
    case (state)
      IDLE: begin
        if (start) nextState = boxValid ? SCAN : ERR;
      end
      SCAN: begin
        busy        = 1'b1;
        mem_address = ADDR_SZ'(yQ) * ADDR_SZ'(X_RES) + ADDR_SZ'(xQ);
        mem_data    = colourQ;
        wren        = fillQ || onEdge;
        if (lastCol && lastRow) nextState = DONE;
      end
      DONE: begin
        done      = 1'b1;
        nextState = IDLE;
      end
      ERR: begin
        done      = 1'b1;
        err       = 1'b1;
        nextState = IDLE;
      end
      default: nextState = IDLE;
    endcase
  end

endmodule

// File: tb/tb_draw_bounding_box.sv
// Directed bench for draw_bounding_box: expected scan pixels and done pulses are queued
// by the stimulus and checked by a negedge monitor whenever the DUT presents them.
module tb_draw_bounding_box;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic       fill = 1'b0;
  logic [2:0] mostTop = '0, mostBottom = '0, mostLeft = '0, mostRight = '0;
  logic [2:0] colour = '0;
  logic [5:0] mem_address;
  logic [2:0] mem_data;
  logic       wren, busy, done, err;

  draw_bounding_box dut (
    .clk(clk), .reset(reset), .start(start), .fill(fill),
    .mostTop(mostTop), .mostBottom(mostBottom), .mostLeft(mostLeft), .mostRight(mostRight),
    .colour(colour), .mem_address(mem_address), .mem_data(mem_data),
    .wren(wren), .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [5:0] addr;
    logic [2:0] data;
    logic       we;
  } scanT;

  typedef struct {
    logic err;
    int   cyc;
  } doneT;

  scanT scanQ[$];
  doneT doneQ[$];
  int   total = 0;
  int   bad = 0;
  int   cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (cyc %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic pushScan(input int addr, input int data, input bit we);
    scanT s;
    s.addr = 6'(addr);
    s.data = 3'(data);
    s.we   = we;
    scanQ.push_back(s);
  endtask

  task automatic pushDone(input bit e, input int c);
    doneT d;
    d.err = e;
    d.cyc = c;
    doneQ.push_back(d);
  endtask

  // monitor
  scanT mS;
  doneT mD;
  always @(negedge clk) begin
    if (busy === 1'b1) begin
      if (scanQ.size() == 0) begin
        check("unexpected_scan_cycle", {26'd0, mem_address}, 32'hFFFF_FFFF);
      end else begin
        mS = scanQ.pop_front();
        check("scan_addr", {26'd0, mem_address}, {26'd0, mS.addr});
        check("scan_data", {29'd0, mem_data}, {29'd0, mS.data});
        check("scan_wren", {31'd0, wren}, {31'd0, mS.we});
      end
    end else if (wren !== 1'b0 && reset === 1'b0) begin
      check("wren_outside_scan", {31'd0, wren}, 32'd0);
    end
    if (done === 1'b1) begin
      if (doneQ.size() == 0) begin
        check("unexpected_done", {31'd0, done}, 32'd0);
      end else begin
        mD = doneQ.pop_front();
        check("done_err", {31'd0, err}, {31'd0, mD.err});
        check("done_cycle", cyc, mD.cyc);
      end
    end else if (err !== 1'b0 && reset === 1'b0) begin
      check("err_without_done", {31'd0, err}, 32'd0);
    end
  end

  // Drive one start pulse; returns k, the cycle count after the sampling edge.
  task automatic startDraw(input int t, input int b, input int l, input int r,
                           input int c, input bit f, output int k);
    @(posedge clk) #1;
    mostTop = 3'(t); mostBottom = 3'(b); mostLeft = 3'(l); mostRight = 3'(r);
    colour = 3'(c); fill = f; start = 1'b1;
    k = cyc + 1;
    @(posedge clk) #1;
    start = 1'b0;
    mostTop = 3'd5; mostBottom = 3'd0; mostLeft = 3'd7; mostRight = 3'd0;
    colour = 3'd0; fill = ~f;
  endtask

  task automatic waitDrain(input string name);
    int n = 0;
    while ((scanQ.size() != 0 || doneQ.size() != 0) && n < 200) begin
      @(posedge clk);
      n++;
    end
    total++;
    if (n >= 200) begin
      bad++;
      $display("FAIL %s_timeout: pending scan=%0d done=%0d expected 0", name, scanQ.size(), doneQ.size());
      scanQ.delete();
      doneQ.delete();
    end
    repeat (3) @(posedge clk);
    #1;
  endtask

  int outA[9] = '{7, 8, 9, 13, 14, 15, 19, 20, 21};
  int k;

  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_addr", {26'd0, mem_address}, 32'd0);
    check("rst_data", {29'd0, mem_data}, 32'd0);
    check("rst_wren", {31'd0, wren}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_err", {31'd0, err}, 32'd0);
    @(posedge clk) #1;
    reset = 1'b0;

    // outline (1,1)-(3,3), colour 5
    startDraw(1, 3, 1, 3, 5, 1'b0, k);
    foreach (outA[i]) pushScan(outA[i], 5, outA[i] != 14);
    pushDone(1'b0, k + 9);
    waitDrain("outline");

    // fill (4,4)-(5,5), colour 7
    startDraw(4, 5, 4, 5, 7, 1'b1, k);
    pushScan(28, 7, 1); pushScan(29, 7, 1); pushScan(34, 7, 1); pushScan(35, 7, 1);
    pushDone(1'b0, k + 4);
    waitDrain("fill");

    // single pixel (3,2)
    startDraw(2, 2, 3, 3, 2, 1'b0, k);
    pushScan(15, 2, 1);
    pushDone(1'b0, k + 1);
    waitDrain("single");

    // one-row outline: every pixel is perimeter
    startDraw(0, 0, 0, 3, 6, 1'b0, k);
    pushScan(0, 6, 1); pushScan(1, 6, 1); pushScan(2, 6, 1); pushScan(3, 6, 1);
    pushDone(1'b0, k + 4);
    waitDrain("row");

    // rejected boxes
    startDraw(0, 1, 4, 2, 3, 1'b1, k);
    pushDone(1'b1, k);
    waitDrain("inv_lr");
    startDraw(0, 0, 0, 6, 3, 1'b0, k);
    pushDone(1'b1, k);
    waitDrain("inv_right6");
    startDraw(6, 7, 0, 0, 3, 1'b1, k);
    pushDone(1'b1, k);
    waitDrain("inv_bottom");

    // reset in scan cycle 10 of a full-frame fill
    startDraw(0, 5, 0, 5, 1, 1'b1, k);
    for (int a = 0; a < 10; a++) pushScan(a, 1, 1);
    repeat (9) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk) #1;
    reset = 1'b0;
    @(negedge clk);
    check("postrst_busy", {31'd0, busy}, 32'd0);
    check("postrst_wren", {31'd0, wren}, 32'd0);
    check("postrst_done", {31'd0, done}, 32'd0);
    waitDrain("reset_scan");

    // reset and start on the same edge: start is lost
    @(posedge clk) #1;
    mostTop = 3'd0; mostBottom = 3'd1; mostLeft = 3'd0; mostRight = 3'd1;
    colour = 3'd3; fill = 1'b1; start = 1'b1; reset = 1'b1;
    @(posedge clk) #1;
    start = 1'b0; reset = 1'b0;
    waitDrain("reset_start");

    // fresh draw starts again from address 0
    startDraw(0, 1, 0, 1, 4, 1'b1, k);
    pushScan(0, 4, 1); pushScan(1, 4, 1); pushScan(6, 4, 1); pushScan(7, 4, 1);
    pushDone(1'b0, k + 4);
    waitDrain("redraw");

    // start mid-scan with other coordinates is ignored
    startDraw(1, 3, 1, 3, 5, 1'b0, k);
    foreach (outA[i]) pushScan(outA[i], 5, outA[i] != 14);
    pushDone(1'b0, k + 9);
    @(posedge clk) #1;
    mostTop = 3'd0; mostBottom = 3'd5; mostLeft = 3'd0; mostRight = 3'd5;
    colour = 3'd2; fill = 1'b1; start = 1'b1;
    @(posedge clk) #1;
    start = 1'b0;
    waitDrain("midscan_start");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
